// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin time-sharing of one Q16.16 divider among
// NUM_REQ requesters. Captures the selected operands, runs the divider's
// start/done handshake and returns one registered quotient per divide.
// Optional build macro: DIV_SHARE_ZERO_BYPASS_EN (a zero divisor returns a
// saturated quotient without starting the divider).
module div_share_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_dividend,
   input  logic [NUM_REQ*DATA_W-1:0] i_divisor,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic [NUM_REQ-1:0]        o_done,
   output logic [DATA_W-1:0]         o_quotient,
   output logic                      o_busy,
   output logic                      o_div_start,
   output logic [DATA_W-1:0]         o_div_dividend,
   output logic [DATA_W-1:0]         o_div_divisor,
   input  logic [DATA_W-1:0]         i_div_quotient,
   input  logic                      i_div_done
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETIRE} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     sel_q, sel_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [DATA_W-1:0]    quot_q, quot_d;
   logic                 start_q, start_d;
   logic [DATA_W-1:0]    dvd_q, dvd_d;
   logic [DATA_W-1:0]    dvs_q, dvs_d;

   logic                 pick_vld;
   logic [PTR_W-1:0]     pick;
   logic [DATA_W-1:0]    pick_dvd;
   logic [DATA_W-1:0]    pick_dvs;

   // (base + off) mod NUM_REQ; off never exceeds NUM_REQ-1
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // First requesting index at or after rr_ptr, scanning with wrap-around
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!pick_vld && i_req[wrap_idx(rr_ptr_q, i)]) begin
            pick_vld = 1'b1;
            pick     = wrap_idx(rr_ptr_q, i);
         end
      end
   end

   assign pick_dvd = i_dividend[pick*DATA_W +: DATA_W];
   assign pick_dvs = i_divisor[pick*DATA_W +: DATA_W];

   // Next-state and registered-output logic for IDLE -> WAIT -> RETIRE
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      grant_d  = grant_q;
      done_d   = '0;
      quot_d   = quot_q;
      start_d  = 1'b0;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               sel_d       = pick;
               dvd_d       = pick_dvd;
               dvs_d       = pick_dvs;
               grant_d     = '0;
               grant_d[pick] = 1'b1;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
               if (pick_dvs == '0) begin
                  // Saturate toward the dividend's sign; never touch the divider
                  done_d[pick] = 1'b1;
                  quot_d       = pick_dvd[DATA_W-1] ? {1'b1, {(DATA_W-2){1'b0}}, 1'b1}
                                                    : {1'b0, {(DATA_W-1){1'b1}}};
                  rr_ptr_d     = next_ptr(pick);
                  state_d      = S_RETIRE;
               end else begin
                  start_d = 1'b1;
                  state_d = S_WAIT;
               end
`else
               start_d = 1'b1;
               state_d = S_WAIT;
`endif
            end
         end
         S_WAIT: begin
            if (i_div_done) begin
               quot_d        = i_div_quotient;
               done_d[sel_q] = 1'b1;
               rr_ptr_d      = next_ptr(sel_q);
               state_d       = S_RETIRE;
            end
         end
         S_RETIRE: begin
            // Requests are ignored here so the served requester can drop its level
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight divide
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         sel_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         quot_q   <= '0;
         start_q  <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         sel_q    <= sel_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         quot_q   <= quot_d;
         start_q  <= start_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
      end
   end

   assign o_grant        = grant_q;
   assign o_done         = done_q;
   assign o_quotient     = quot_q;
   assign o_busy         = (state_q != S_IDLE);
   assign o_div_start    = start_q;
   assign o_div_dividend = dvd_q;
   assign o_div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency divider model.
module tb_div_share_arbiter;
   localparam int N = 3;
   localparam int W = 32;
   localparam int L = 34;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic [N-1:0]   i_req = '0;
   logic [N*W-1:0] i_dividend = '0;
   logic [N*W-1:0] i_divisor = '0;
   logic [N-1:0]   o_grant, o_done;
   logic [W-1:0]   o_quotient, o_div_dividend, o_div_divisor;
   logic           o_busy, o_div_start;
   logic [W-1:0]   i_div_quotient = '0;
   logic           i_div_done = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   div_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
      .i_dividend(i_dividend), .i_divisor(i_divisor),
      .o_grant(o_grant), .o_done(o_done), .o_quotient(o_quotient),
      .o_busy(o_busy), .o_div_start(o_div_start),
      .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
      .i_div_quotient(i_div_quotient), .i_div_done(i_div_done)
   );

   initial forever #5 i_clk = ~i_clk;

   // Divider model: Q16.16 divide, done L cycles after the start cycle.
   // Ignores reset so a stale done can follow a mid-divide reset.
   int          m_cnt = 0;
   logic        m_busy = 1'b0;
   logic [W-1:0] m_q = '0;
   int          stale_seen = 0;

   function automatic logic [W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
      longint n, d;
      n = longint'($signed(a)) * 65536;
      d = longint'($signed(b));
      if (d == 0) return 32'hDEADBEEF;
      return W'(n / d);
   endfunction

   always @(posedge i_clk) begin
      i_div_done <= 1'b0;
      if (o_div_start) begin
         m_cnt  <= L - 1;
         m_busy <= 1'b1;
         m_q    <= model_div(o_div_dividend, o_div_divisor);
      end else if (m_busy) begin
         if (m_cnt == 1) begin
            i_div_done     <= 1'b1;
            i_div_quotient <= m_q;
            m_busy         <= 1'b0;
         end else m_cnt <= m_cnt - 1;
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Raise one request at the current negedge (cycle T) and follow it to o_done.
   // ts/td are cycle offsets from T (-1 when never seen within the bound).
   task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int ts, output int td, output logic [W-1:0] q,
                        output logic [N-1:0] dv, output logic [N-1:0] g1);
      i_dividend[idx*W +: W] = a;
      i_divisor[idx*W +: W]  = b;
      i_req[idx] = 1'b1;
      ts = -1; td = -1; q = '0; dv = '0; g1 = '0;
      for (int k = 1; k <= 100 && td < 0; k++) begin
         @(negedge i_clk);
         if (o_div_start && ts < 0) begin ts = k; g1 = o_grant; end
         if (o_done != '0) begin td = k; q = o_quotient; dv = o_done; i_req[idx] = 1'b0; end
      end
      i_req[idx] = 1'b0;
   endtask

   typedef struct {
      int           idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int ts, td, k;
      logic [W-1:0] q;
      logic [N-1:0] dv, g1;
      int           d_t[3];
      logic [N-1:0] d_v[3];
      logic [W-1:0] d_q[3];
      int           nd, bad;
      logic [N-1:0] g_d0, g_d1, g_d2;
      logic         s_d2;

      vecs[0] = '{0, 32'h00060000, 32'h00020000, 32'h00030000};
      vecs[1] = '{1, 32'hFFFA0000, 32'h00020000, 32'hFFFD0000};
      vecs[2] = '{2, 32'h00010000, 32'h00030000, 32'h00005555};
      vecs[3] = '{0, 32'h7FFF0000, 32'h00010000, 32'h7FFF0000};
      vecs[4] = '{1, 32'hFFFE8000, 32'h00008000, 32'hFFFD0000};
      vecs[5] = '{2, 32'h00010000, 32'hFFFF0000, 32'hFFFF0000};

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("rst_grant", W'(o_grant), '0);
      chk("rst_done", W'(o_done), '0);
      chk("rst_start", W'(o_div_start), '0);
      chk("rst_busy", W'(o_busy), '0);
      chk("rst_quot", o_quotient, '0);
      chk("rst_dvd", o_div_dividend, '0);
      chk("rst_dvs", o_div_divisor, '0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // All three at once: served 0,1,2, dones 37 cycles apart
      i_dividend = {32'hFFF80000, 32'h00010000, 32'h00060000};
      i_divisor  = {32'h00020000, 32'h00040000, 32'h00020000};
      i_req = 3'b111;
      nd = 0;
      for (k = 1; k <= 200 && nd < 3; k++) begin
         @(negedge i_clk);
         if (o_done != '0) begin
            d_t[nd] = k; d_v[nd] = o_done; d_q[nd] = o_quotient;
            i_req = i_req & ~o_done;
            nd++;
         end
      end
      i_req = '0;
      chk("all3_count", W'(nd), 32'd3);
      if (nd == 3) begin
         chk("all3_first", W'(d_v[0]), 32'b001);
         chk("all3_second", W'(d_v[1]), 32'b010);
         chk("all3_third", W'(d_v[2]), 32'b100);
         chk("all3_t0", W'(d_t[0]), 32'd36);
         chk("all3_gap1", W'(d_t[1] - d_t[0]), 32'd37);
         chk("all3_gap2", W'(d_t[2] - d_t[1]), 32'd37);
         chk("all3_q0", d_q[0], 32'h00030000);
         chk("all3_q1", d_q[1], 32'h00004000);
         chk("all3_q2", d_q[2], 32'hFFFC0000);
      end
      @(negedge i_clk);

      // Fairness: after serving 1, requesters 0 and 2 together -> 2 first
      issue(1, 32'h000A0000, 32'h00050000, ts, td, q, dv, g1);
      chk("fair_pre_q", q, 32'h00020000);
      @(negedge i_clk);
      i_dividend[0 +: W] = 32'h00040000; i_divisor[0 +: W] = 32'h00020000;
      i_dividend[2*W +: W] = 32'h00090000; i_divisor[2*W +: W] = 32'h00030000;
      i_req = 3'b101;
      nd = 0;
      for (k = 1; k <= 200 && nd < 2; k++) begin
         @(negedge i_clk);
         if (o_done != '0) begin
            d_v[nd] = o_done; d_q[nd] = o_quotient;
            i_req = i_req & ~o_done;
            nd++;
         end
      end
      i_req = '0;
      chk("fair_count", W'(nd), 32'd2);
      if (nd == 2) begin
         chk("fair_first", W'(d_v[0]), 32'b100);
         chk("fair_first_q", d_q[0], 32'h00030000);
         chk("fair_second", W'(d_v[1]), 32'b001);
         chk("fair_second_q", d_q[1], 32'h00020000);
      end
      @(negedge i_clk);

      // Table of single divides
      foreach (vecs[i]) begin
         issue(vecs[i].idx, vecs[i].a, vecs[i].b, ts, td, q, dv, g1);
         chk($sformatf("v%0d_start_t", i), W'(ts), 32'd1);
         chk($sformatf("v%0d_grant", i), W'(g1), W'(1 << vecs[i].idx));
         chk($sformatf("v%0d_done_t", i), W'(td), 32'd36);
         chk($sformatf("v%0d_done", i), W'(dv), W'(1 << vecs[i].idx));
         chk($sformatf("v%0d_quot", i), q, vecs[i].q);
         @(negedge i_clk);
         chk($sformatf("v%0d_busy_after", i), W'(o_busy), '0);
         chk($sformatf("v%0d_grant_after", i), W'(o_grant), '0);
      end

      // Held request: reissued after one grant-low cycle
      i_dividend[0 +: W] = 32'h00080000; i_divisor[0 +: W] = 32'h00040000;
      i_req = 3'b001;
      td = -1;
      for (k = 1; k <= 100 && td < 0; k++) begin
         @(negedge i_clk);
         if (o_done != '0) td = k;
      end
      chk("held_done_t", W'(td), 32'd36);
      g_d0 = o_grant;
      @(negedge i_clk); g_d1 = o_grant;
      @(negedge i_clk); g_d2 = o_grant; s_d2 = o_div_start;
      chk("held_grant_at_done", W'(g_d0), 32'b001);
      chk("held_grant_gap", W'(g_d1), 32'b000);
      chk("held_grant_again", W'(g_d2), 32'b001);
      chk("held_restart", W'(s_d2), 32'd1);
      i_req = '0;
      td = -1;
      for (k = 1; k <= 100 && td < 0; k++) begin
         @(negedge i_clk);
         if (o_done != '0) begin td = k; q = o_quotient; end
      end
      chk("held_second_done_t", W'(td), 32'd35);
      chk("held_second_q", q, 32'h00020000);
      @(negedge i_clk);

      // Zero divisor on requester 1
      issue(1, 32'hFFFF0000, 32'h00000000, ts, td, q, dv, g1);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
      chk("zero_no_start", W'(ts), 32'hFFFFFFFF);
      chk("zero_done_t", W'(td), 32'd1);
      chk("zero_done", W'(dv), 32'b010);
      chk("zero_grant_with_done", W'(o_grant), 32'b010);
      chk("zero_quot", q, 32'h80000001);
`else
      chk("zero_start_t", W'(ts), 32'd1);
      chk("zero_done_t", W'(td), 32'd36);
      chk("zero_done", W'(dv), 32'b010);
      chk("zero_quot", q, 32'hDEADBEEF);
`endif
      @(negedge i_clk);

      // Mid-divide reset: nothing retires, stale done ignored
      i_dividend[0 +: W] = 32'h00060000; i_divisor[0 +: W] = 32'h00020000;
      i_req = 3'b001;
      stale_seen = 0;
      for (k = 1; k <= 10; k++) @(negedge i_clk);
      i_rst = 1'b1; i_req = '0;
      @(negedge i_clk);
      chk("mrst_grant", W'(o_grant), '0);
      chk("mrst_done", W'(o_done), '0);
      chk("mrst_start", W'(o_div_start), '0);
      chk("mrst_busy", W'(o_busy), '0);
      chk("mrst_quot", o_quotient, '0);
      chk("mrst_dvd", o_div_dividend, '0);
      chk("mrst_dvs", o_div_divisor, '0);
      i_rst = 1'b0;
      bad = 0;
      for (k = 12; k <= 45; k++) begin
         @(negedge i_clk);
         if (i_div_done) stale_seen++;
         if (o_done != '0 || o_busy || o_div_start || o_grant != '0) bad++;
      end
      chk("mrst_stale_pulse_seen", W'(stale_seen), 32'd1);
      chk("mrst_quiet", W'(bad), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end
endmodule
